// File: rtl/kamacore_fetch_unit_pkg.sv
// Shared kamacore definitions: datapath widths, fetch FSM states and the
// branch-target helper used by the fetch unit.
package kamacore_fetch_unit_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Wrapping sum of branch PC and offset, forced to word alignment.
  function automatic logic [ADDR_WIDTH-1:0] calc_target(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] offset
  );
    logic [ADDR_WIDTH-1:0] sum;
    sum = base + offset;
    return {sum[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/kamacore_fetch_unit_if.sv
// Instruction-memory request/response and decode handshake bundle between
// the fetch unit (master) and its memory/decode neighbours (slave).
interface kamacore_fetch_unit_if;
  import kamacore_fetch_unit_pkg::*;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [CPU_WIDTH-1:0]  mem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [CPU_WIDTH-1:0]  inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready
  );

endinterface

// File: rtl/kamacore_fetch_unit.sv
// Single-outstanding instruction fetcher with a one-entry decode buffer and
// taken-branch redirect that squashes any in-flight response.
module kamacore_fetch_unit
  import kamacore_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_pc,
  input  logic [ADDR_WIDTH-1:0]  branch_offset,
  kamacore_fetch_unit_if.master  bus
);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic                  discard, discard_next;
  logic                  capture;
  logic [CPU_WIDTH-1:0]  inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [ADDR_WIDTH-1:0] target;

  assign target = calc_target(branch_pc, branch_offset);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_ADDR;
      discard   <= 1'b0;
      inst_data <= '0;
      inst_pc   <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      discard <= discard_next;
      if (capture) begin
        inst_data <= bus.mem_rsp_data;
        inst_pc   <= pc;
      end
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    capture      = 1'b0;
    unique case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (branch_valid) pc_next = target;
        if (bus.mem_req_ready) begin
          state_next = ST_WAIT;
          // The request just accepted used the old pc, so its data is stale.
          if (branch_valid) discard_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (branch_valid) begin
          pc_next = target;
          if (bus.mem_rsp_valid) begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else begin
            discard_next = 1'b1;
          end
        end else if (bus.mem_rsp_valid) begin
          if (discard) begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else begin
            capture    = 1'b1;
            pc_next    = pc + ADDR_WIDTH'(4);
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Redirect wins over delivery: the buffered word is on the wrong path.
        if (branch_valid) begin
          pc_next    = target;
          state_next = ST_REQ;
        end else if (bus.inst_ready) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = (state == ST_REQ);
    bus.mem_req_addr  = pc;
    bus.inst_valid    = (state == ST_HOLD);
    bus.inst_data     = inst_data;
    bus.inst_pc       = inst_pc;
  end

endmodule

// File: tb/tb_kamacore_fetch_unit.sv
// Directed bench for the fetch unit: a hand-driven memory and decode stage
// step through sequential fetch, stalls, redirects, wrap and reset abort.
module tb_kamacore_fetch_unit;
  import kamacore_fetch_unit_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  branch_valid;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [ADDR_WIDTH-1:0] branch_offset;
  int                    total = 0;
  int                    bad = 0;

  kamacore_fetch_unit_if bus();

  kamacore_fetch_unit #(.RESET_ADDR(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_valid  (branch_valid),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From REQ with ready high: check the request, then move to WAIT.
  task automatic do_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, bus.mem_req_addr, addr);
    $display("req  %s addr=%h", tag, bus.mem_req_addr);
    tick();
  endtask

  // From WAIT: present one response beat.
  task automatic do_rsp(input logic [31:0] data);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
    chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd1);
    chk({tag, "_inst_pc"}, bus.inst_pc, pc);
    chk({tag, "_inst_data"}, bus.inst_data, data);
    $display("inst %s pc=%h data=%h", tag, bus.inst_pc, bus.inst_data);
  endtask

  initial begin
    rst_n             = 1'b0;
    branch_valid      = 1'b0;
    branch_pc         = '0;
    branch_offset     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.inst_ready    = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h100);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_data", bus.inst_data, 32'h0);

    // Sequential fetch from RESET_ADDR.
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b1;
    bus.inst_ready    = 1'b1;
    tick();
    do_req("seq0", 32'h100);
    chk("seq0_wait_no_req", 32'(bus.mem_req_valid), 32'd0);
    do_rsp(32'h0000_0013);
    chk_inst("seq0", 32'h100, 32'h0000_0013);
    tick();
    do_req("seq1", 32'h104);
    do_rsp(32'h0000_0013);
    chk_inst("seq1", 32'h104, 32'h0000_0013);
    tick();
    do_req("seq2", 32'h108);

    // Decode stall for five cycles.
    bus.inst_ready = 1'b0;
    do_rsp(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      chk_inst("stall", 32'h108, 32'hDEAD_BEEF);
      chk("stall_no_req", 32'(bus.mem_req_valid), 32'd0);
      tick();
    end
    chk_inst("stall_end", 32'h108, 32'hDEAD_BEEF);
    bus.inst_ready = 1'b1;
    tick();

    // Redirect while waiting: the in-flight word must be dropped.
    do_req("bwait", 32'h10C);
    branch_valid = 1'b1; branch_pc = 32'h104; branch_offset = 32'h20;
    tick();
    branch_valid = 1'b0;
    chk("bwait_no_inst", 32'(bus.inst_valid), 32'd0);
    do_rsp(32'h0000_0BAD);
    chk("bwait_drop_inst", 32'(bus.inst_valid), 32'd0);
    do_req("bwait_tgt", 32'h124);

    // Redirect and inst_ready together in HOLD: redirect wins.
    do_rsp(32'h0000_0055);
    chk_inst("bhold", 32'h124, 32'h0000_0055);
    branch_valid = 1'b1; branch_pc = 32'h200; branch_offset = 32'hFFFF_FFF8;
    tick();
    branch_valid = 1'b0;
    chk("bhold_drop", 32'(bus.inst_valid), 32'd0);

    // Redirect in REQ with ready: accepted request gets discarded; odd target aligned.
    branch_valid = 1'b1; branch_pc = 32'h1000; branch_offset = 32'h13;
    do_req("breq_rdy", 32'h1F8);
    branch_valid = 1'b0;
    do_rsp(32'h0000_0666);
    chk("breq_rdy_drop", 32'(bus.inst_valid), 32'd0);

    // Redirect in REQ without ready: stays in REQ with new address.
    bus.mem_req_ready = 1'b0;
    branch_valid = 1'b1; branch_pc = 32'hFFFF_FFF0; branch_offset = 32'h0C;
    do_req("breq_stall", 32'h1010);
    branch_valid = 1'b0;
    bus.mem_req_ready = 1'b1;

    // Top-of-space fetch wraps to zero.
    do_req("wrap", 32'hFFFF_FFFC);
    do_rsp(32'h1234_5678);
    chk_inst("wrap", 32'hFFFF_FFFC, 32'h1234_5678);
    tick();

    // Response outside WAIT is ignored.
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("stray_rsp_no_inst", 32'(bus.inst_valid), 32'd0);
    bus.mem_req_ready = 1'b1;
    do_req("wrap_tgt", 32'h0);

    // Redirect in WAIT coincident with response.
    do_rsp(32'h0000_0AAA);
    tick();
    do_req("bw_rsp_pre", 32'h4);
    branch_valid = 1'b1; branch_pc = 32'h0; branch_offset = 32'h40;
    do_rsp(32'h0000_0BBB);
    branch_valid = 1'b0;
    chk("bw_rsp_no_inst", 32'(bus.inst_valid), 32'd0);
    do_req("bw_rsp_tgt", 32'h40);

    // Reset during WAIT, then a late response.
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("mid_rst_req_addr", bus.mem_req_addr, 32'h100);
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("late_rsp_no_inst", 32'(bus.inst_valid), 32'd0);
    do_req("post_rst", 32'h100);
    do_rsp(32'h0000_0077);
    chk_inst("post_rst", 32'h100, 32'h0000_0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
